// File: rtl/spad_stream_loader.sv
// Stream-to-scratchpad loader: fills up to NUM_SPADS scratchpads from a valid/ready
// stream, waits a programmable gap, then holds route enable until the datapath finishes.
//   state   | meaning
//   S_IDLE  | waiting for a start
//   S_LOAD  | accepting stream words into the current scratchpad
//   S_GAP   | final write issued, counting down the route delay
//   S_ROUTE | route enable held until route done
module spad_stream_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_SPADS  = 2,
  parameter int GAP_WIDTH  = 4,
  localparam int SEL_W     = (NUM_SPADS > 1) ? $clog2(NUM_SPADS) : 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_nrst,
  input  logic                                 i_start,
  input  logic                                 i_abort,
  input  logic [NUM_SPADS*(ADDR_WIDTH+1)-1:0]  i_load_len,
  input  logic [GAP_WIDTH-1:0]                 i_gap,
  input  logic [DATA_WIDTH-1:0]                i_s_data,
  input  logic                                 i_s_valid,
  output logic                                 o_s_ready,
  output logic                                 o_write_en,
  output logic [ADDR_WIDTH-1:0]                o_write_addr,
  output logic [SEL_W-1:0]                     o_spad_select,
  output logic [DATA_WIDTH-1:0]                o_data_in,
  output logic [NUM_SPADS*ADDR_WIDTH-1:0]      o_last_addr,
  output logic                                 o_route_en,
  input  logic                                 i_route_done,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GAP, S_ROUTE} state_t;

  state_t                          state_q, state_d;
  logic [NUM_SPADS*LEN_W-1:0]      len_q, len_d;
  logic [SEL_W-1:0]                spad_q, spad_d;
  logic [ADDR_WIDTH-1:0]           cnt_q, cnt_d;
  logic [GAP_WIDTH-1:0]            gap_cnt_q, gap_cnt_d;
  logic                            wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]           wr_addr_q, wr_addr_d;
  logic [SEL_W-1:0]                wr_sel_q, wr_sel_d;
  logic [DATA_WIDTH-1:0]           wr_data_q, wr_data_d;
  logic [NUM_SPADS*ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                            err_q, err_d;
  logic                            done_q, done_d;

  logic             len_bad, len_all_zero;
  logic [SEL_W-1:0] first_nz;
  logic [SEL_W-1:0] next_nz;
  logic             next_found;
  logic [LEN_W-1:0] cur_len;
  logic             last_word;

  // Start-time length screening and the first scratchpad that has work.
  always_comb begin
    len_bad      = 1'b0;
    len_all_zero = 1'b1;
    first_nz     = '0;
    for (int k = NUM_SPADS - 1; k >= 0; k--) begin
      if (i_load_len[k*LEN_W +: LEN_W] > MAX_LEN) len_bad = 1'b1;
      if (i_load_len[k*LEN_W +: LEN_W] != '0) begin
        len_all_zero = 1'b0;
        first_nz     = SEL_W'(k);
      end
    end
  end

  // Next scratchpad after the current one with a nonzero length (lowest index wins).
  always_comb begin
    next_nz    = '0;
    next_found = 1'b0;
    for (int k = NUM_SPADS - 1; k >= 0; k--) begin
      if (k > int'(spad_q) && len_q[k*LEN_W +: LEN_W] != '0) begin
        next_nz    = SEL_W'(k);
        next_found = 1'b1;
      end
    end
  end

  assign cur_len   = len_q[int'(spad_q)*LEN_W +: LEN_W];
  assign last_word = ({1'b0, cnt_q} == (cur_len - LEN_W'(1)));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    spad_d      = spad_q;
    cnt_d       = cnt_q;
    gap_cnt_d   = gap_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_sel_d    = wr_sel_q;
    wr_data_d   = wr_data_q;
    last_addr_d = last_addr_q;
    err_d       = err_q;
    done_d      = 1'b0;

    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            if (len_bad || len_all_zero) begin
              err_d = 1'b1;
            end else begin
              err_d     = 1'b0;
              len_d     = i_load_len;
              gap_cnt_d = i_gap;
              spad_d    = first_nz;
              cnt_d     = '0;
              state_d   = S_LOAD;
              for (int k = 0; k < NUM_SPADS; k++) begin
                if (i_load_len[k*LEN_W +: LEN_W] == '0)
                  last_addr_d[k*ADDR_WIDTH +: ADDR_WIDTH] = '0;
              end
            end
          end
        end
        S_LOAD: begin
          if (i_s_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_sel_d  = spad_q;
            wr_data_d = i_s_data;
            if (last_word) begin
              last_addr_d[int'(spad_q)*ADDR_WIDTH +: ADDR_WIDTH] = cnt_q;
              cnt_d = '0;
              if (next_found) spad_d  = next_nz;
              else            state_d = S_GAP;
            end else begin
              cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        S_GAP: begin
          // The first GAP cycle carries the final write strobe.
          if (gap_cnt_q == '0) state_d = S_ROUTE;
          else                 gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
        S_ROUTE: begin
          if (i_route_done) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      spad_q      <= '0;
      cnt_q       <= '0;
      gap_cnt_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_sel_q    <= '0;
      wr_data_q   <= '0;
      last_addr_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      spad_q      <= spad_d;
      cnt_q       <= cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_sel_q    <= wr_sel_d;
      wr_data_q   <= wr_data_d;
      last_addr_q <= last_addr_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign o_s_ready     = (state_q == S_LOAD);
  assign o_route_en    = (state_q == S_ROUTE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_write_en    = wr_en_q;
  assign o_write_addr  = wr_addr_q;
  assign o_spad_select = wr_sel_q;
  assign o_data_in     = wr_data_q;
  assign o_last_addr   = last_addr_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_spad_stream_loader.sv
// Directed bench for spad_stream_loader: an SRAM model captures writes and
// every check goes through chk_eq against hand-computed values.
module tb_spad_stream_loader;

  logic          i_clk = 1'b0;
  logic          i_nrst, i_start, i_abort, i_s_valid, i_route_done;
  logic [17:0]   i_load_len;
  logic [3:0]    i_gap;
  logic [63:0]   i_s_data;
  logic          o_s_ready, o_write_en, o_route_en, o_busy, o_done, o_err;
  logic [7:0]    o_write_addr;
  logic [0:0]    o_spad_select;
  logic [63:0]   o_data_in;
  logic [15:0]   o_last_addr;

  spad_stream_loader dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_abort(i_abort),
    .i_load_len(i_load_len), .i_gap(i_gap), .i_s_data(i_s_data), .i_s_valid(i_s_valid),
    .o_s_ready(o_s_ready), .o_write_en(o_write_en), .o_write_addr(o_write_addr),
    .o_spad_select(o_spad_select), .o_data_in(o_data_in), .o_last_addr(o_last_addr),
    .o_route_en(o_route_en), .i_route_done(i_route_done), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SRAM model and monitors; only this block writes them, clearing on request.
  logic [63:0] mem [0:1][0:255];
  int wr_cnt [0:1];
  int exp_addr [0:1];
  int lat_err, order_err, done_cnt, last_wr_cyc, route_rise_cyc;
  int clr_gen = 0;
  int seen_gen = 0;
  logic route_prev = 1'b0;
  logic hs_prev;
  int cyc = 0;
  int hs_cnt = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) hs_prev <= 1'b0;
    else begin
      hs_prev <= i_s_valid & o_s_ready & ~i_abort;
      if (i_s_valid & o_s_ready & ~i_abort) hs_cnt <= hs_cnt + 1;
    end
  end

  always @(negedge i_clk) begin
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      for (int s = 0; s < 2; s++) begin
        wr_cnt[s] = 0;
        exp_addr[s] = 0;
        for (int a = 0; a < 256; a++) mem[s][a] = '0;
      end
      lat_err = 0; order_err = 0; done_cnt = 0;
    end
    if (o_write_en !== hs_prev) lat_err++;
    if (o_write_en) begin
      if (int'(o_write_addr) != exp_addr[o_spad_select]) order_err++;
      mem[o_spad_select][o_write_addr] = o_data_in;
      wr_cnt[o_spad_select]++;
      exp_addr[o_spad_select]++;
      last_wr_cyc = cyc;
    end
    if (o_route_en && !route_prev) route_rise_cyc = cyc;
    route_prev = o_route_en;
    if (o_done) done_cnt++;
  end

  function automatic int bad_words(input int s, input int n, input logic [63:0] first);
    int b = 0;
    for (int a = 0; a < n; a++) if (mem[s][a] !== first + 64'(a)) b++;
    return b;
  endfunction

  task automatic clear_model();
    clr_gen++;
    @(negedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic start_run(input int l0, input int l1, input int gap);
    @(negedge i_clk);
    i_load_len = {9'(l1), 9'(l0)};
    i_gap      = 4'(gap);
    i_start    = 1'b1;
    @(negedge i_clk);
    i_start    = 1'b0;
  endtask

  task automatic stream(input int n, input logic [63:0] first, input bit rnd, input string tag);
    int base, guard;
    logic v;
    base = hs_cnt;
    guard = 0;
    while ((hs_cnt - base) < n && guard < 4000) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_s_valid = v;
      i_s_data  = v ? first + 64'(hs_cnt - base) : 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge i_clk);
      guard++;
    end
    i_s_valid = 1'b0;
    chk_eq({tag, "_stream_in_time"}, 64'(guard < 4000), 64'd1);
  endtask

  task automatic wait_route(input string tag);
    int guard;
    guard = 0;
    while (!o_route_en && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    chk_eq({tag, "_route_seen"}, 64'(o_route_en), 64'd1);
    @(negedge i_clk);
  endtask

  task automatic finish_route(input string tag);
    i_route_done = 1'b1;
    @(negedge i_clk);
    i_route_done = 1'b0;
    chk_eq({tag, "_done_pulse"}, 64'(o_done), 64'd1);
    chk_eq({tag, "_route_off"}, 64'(o_route_en), 64'd0);
    chk_eq({tag, "_idle"}, 64'(o_busy), 64'd0);
    @(negedge i_clk);
    chk_eq({tag, "_done_one_cycle"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    i_nrst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_s_valid = 1'b0;
    i_route_done = 1'b0; i_load_len = '0; i_gap = '0; i_s_data = '0;
    repeat (3) @(negedge i_clk);
    chk_eq("rst_busy", 64'(o_busy), 64'd0);
    chk_eq("rst_ready", 64'(o_s_ready), 64'd0);
    chk_eq("rst_route", 64'(o_route_en), 64'd0);
    chk_eq("rst_wr", 64'(o_write_en), 64'd0);
    chk_eq("rst_last", 64'(o_last_addr), 64'd0);
    chk_eq("rst_err_done", 64'({o_err, o_done}), 64'd0);
    i_nrst = 1'b1;

    // 1: two spads of 9, gap 2, continuous valid
    clear_model();
    start_run(9, 9, 2);
    stream(18, 64'h01, 1'b0, "t1");
    wait_route("t1");
    chk_eq("t1_route_delay", 64'(route_rise_cyc - last_wr_cyc), 64'd3);
    chk_eq("t1_wr0", 64'(wr_cnt[0]), 64'd9);
    chk_eq("t1_wr1", 64'(wr_cnt[1]), 64'd9);
    chk_eq("t1_data0", 64'(bad_words(0, 9, 64'h01)), 64'd0);
    chk_eq("t1_data1", 64'(bad_words(1, 9, 64'h0A)), 64'd0);
    chk_eq("t1_last", 64'(o_last_addr), 64'h0808);
    chk_eq("t1_order", 64'(order_err), 64'd0);
    chk_eq("t1_latency", 64'(lat_err), 64'd0);
    start_run(300, 1, 0);
    chk_eq("t1_start_ignored_err", 64'(o_err), 64'd0);
    chk_eq("t1_start_ignored_route", 64'(o_route_en), 64'd1);
    finish_route("t1");
    chk_eq("t1_done_cnt", 64'(done_cnt), 64'd1);

    // 2: same run with random valid stalls
    clear_model();
    start_run(9, 9, 2);
    stream(18, 64'h01, 1'b1, "t2");
    wait_route("t2");
    chk_eq("t2_data0", 64'(bad_words(0, 9, 64'h01)), 64'd0);
    chk_eq("t2_data1", 64'(bad_words(1, 9, 64'h0A)), 64'd0);
    chk_eq("t2_wr_total", 64'(wr_cnt[0] + wr_cnt[1]), 64'd18);
    chk_eq("t2_latency", 64'(lat_err), 64'd0);
    finish_route("t2");

    // 3: zero-length first spad is skipped and its last address cleared
    clear_model();
    start_run(0, 5, 0);
    stream(5, 64'h40, 1'b0, "t3");
    wait_route("t3");
    chk_eq("t3_route_delay", 64'(route_rise_cyc - last_wr_cyc), 64'd1);
    chk_eq("t3_wr0", 64'(wr_cnt[0]), 64'd0);
    chk_eq("t3_wr1", 64'(wr_cnt[1]), 64'd5);
    chk_eq("t3_data1", 64'(bad_words(1, 5, 64'h40)), 64'd0);
    chk_eq("t3_last", 64'(o_last_addr), 64'h0400);
    finish_route("t3");

    // 4: full-depth spad, then oversize and all-zero rejects
    clear_model();
    start_run(256, 1, 1);
    stream(257, 64'h1000, 1'b0, "t4");
    wait_route("t4");
    chk_eq("t4_wr0", 64'(wr_cnt[0]), 64'd256);
    chk_eq("t4_wr1", 64'(wr_cnt[1]), 64'd1);
    chk_eq("t4_data0", 64'(bad_words(0, 256, 64'h1000)), 64'd0);
    chk_eq("t4_data1", mem[1][0], 64'h1100);
    chk_eq("t4_order", 64'(order_err), 64'd0);
    chk_eq("t4_last", 64'(o_last_addr), 64'h00FF);
    finish_route("t4");
    clear_model();
    start_run(257, 1, 0);
    repeat (3) @(negedge i_clk);
    chk_eq("t4_err", 64'(o_err), 64'd1);
    chk_eq("t4_rej_busy", 64'(o_busy), 64'd0);
    chk_eq("t4_rej_wr", 64'(wr_cnt[0] + wr_cnt[1]), 64'd0);
    start_run(0, 0, 0);
    chk_eq("t4_zero_rej", 64'({o_err, o_busy}), 64'b10);

    // 5: abort after 4 words, then a clean restart
    clear_model();
    start_run(9, 9, 0);
    chk_eq("t5_err_cleared", 64'(o_err), 64'd0);
    stream(4, 64'h01, 1'b0, "t5");
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk_eq("t5_abort_idle", 64'({o_busy, o_s_ready}), 64'd0);
    repeat (3) @(negedge i_clk);
    chk_eq("t5_wr0", 64'(wr_cnt[0]), 64'd4);
    chk_eq("t5_wr1", 64'(wr_cnt[1]), 64'd0);
    chk_eq("t5_data0", 64'(bad_words(0, 4, 64'h01)), 64'd0);
    chk_eq("t5_no_done", 64'(done_cnt), 64'd0);
    chk_eq("t5_latency", 64'(lat_err), 64'd0);
    clear_model();
    start_run(9, 9, 0);
    stream(18, 64'h21, 1'b0, "t5r");
    wait_route("t5r");
    chk_eq("t5r_addr0", mem[0][0], 64'h21);
    chk_eq("t5r_wr0", 64'(wr_cnt[0]), 64'd9);
    chk_eq("t5r_order", 64'(order_err), 64'd0);
    chk_eq("t5r_route_delay", 64'(route_rise_cyc - last_wr_cyc), 64'd1);
    finish_route("t5r");

    // 6: async reset during ROUTE, then a normal run
    clear_model();
    start_run(2, 2, 1);
    stream(4, 64'h50, 1'b0, "t6");
    wait_route("t6");
    #2 i_nrst = 1'b0;
    #1;
    chk_eq("t6_rst_route", 64'(o_route_en), 64'd0);
    chk_eq("t6_rst_busy", 64'(o_busy), 64'd0);
    chk_eq("t6_rst_last", 64'(o_last_addr), 64'd0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    clear_model();
    start_run(9, 9, 2);
    stream(18, 64'h01, 1'b0, "t6r");
    wait_route("t6r");
    chk_eq("t6r_data0", 64'(bad_words(0, 9, 64'h01)), 64'd0);
    chk_eq("t6r_data1", 64'(bad_words(1, 9, 64'h0A)), 64'd0);
    chk_eq("t6r_route_delay", 64'(route_rise_cyc - last_wr_cyc), 64'd3);
    finish_route("t6r");
    chk_eq("t6r_done_cnt", 64'(done_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
